// File: rtl/keccak_pad.sv
// Keccak absorb front end: packs w-bit message words into r-bit rate blocks and
// applies FIPS202 padding (ds suffix + pad10*1). Optional error flag: KECCAK_PAD_ERR_EN.
module keccak_pad #(
  parameter int         d  = 512,
  parameter int         l  = 6,
  parameter int         w  = 2**l,
  parameter int         r  = 25*w - 2*d,
  parameter int         R  = r/w,
  parameter logic [7:0] ds = 8'h06
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [w-1:0]            in_data,
  input  logic                    in_last,
  input  logic [$clog2(w/8):0]    in_bytes,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [r-1:0]            blk_data,
  output logic                    blk_last,
  output logic                    err
);
  localparam int NB = w/8;
  localparam int BW = $clog2(NB) + 1;
  localparam int CW = (R > 1) ? $clog2(R) : 1;

  // lane 0 sits in the MSBs so the packed buffer maps straight onto blk_data
  typedef logic [0:R-1][w-1:0] blk_t;
  typedef enum logic [1:0] {FILL, EMIT, EMIT_PAD} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  blk_t          r_buf;
  logic          r_rdy, r_vld, r_last, r_pend;

  logic          w_acc, w_bad, w_full, w_split;
  logic [BW-1:0] w_n;
  logic [w-1:0]  w_lane;
  blk_t          w_nbuf;

  function automatic blk_t pad_only();
    blk_t b;
    b = '0;
    b[0][7:0]      = ds;
    b[R-1][w-1-:8] = b[R-1][w-1-:8] | 8'h80;
    return b;
  endfunction

  assign w_acc   = in_valid & r_rdy;
  assign w_n     = w_bad ? '0 : in_bytes;
  assign w_full  = int'(w_n) >= NB;
  // full last word landing in the final lane: suffix spills into an extra block
  assign w_split = w_full && (r_cnt == CW'(R-1));

  always_comb begin
    w_lane = '0;
    for (int j = 0; j < NB; j++) begin
      if (!in_last || j < int'(w_n)) w_lane[8*j +: 8] = in_data[8*j +: 8];
      else if (j == int'(w_n))       w_lane[8*j +: 8] = ds;
    end
  end

  always_comb begin
    w_nbuf        = r_buf;
    w_nbuf[r_cnt] = w_lane;
    if (in_last && !w_split) begin
      if (w_full)
        w_nbuf[r_cnt + CW'(1)][7:0] = w_nbuf[r_cnt + CW'(1)][7:0] | ds;
      w_nbuf[R-1][w-1-:8] = w_nbuf[R-1][w-1-:8] | 8'h80;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_rdy   <= 1'b0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          r_rdy <= 1'b1;
          if (w_acc) begin
            r_buf <= w_nbuf;
            if (in_last || r_cnt == CW'(R-1)) begin
              r_state <= EMIT;
              r_rdy   <= 1'b0;
              r_vld   <= 1'b1;
              r_cnt   <= '0;
              r_last  <= in_last && !w_split;
              r_pend  <= in_last && w_split;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        EMIT, EMIT_PAD: begin
          if (blk_ready) begin
            if (r_pend) begin
              r_buf   <= pad_only();
              r_last  <= 1'b1;
              r_pend  <= 1'b0;
              r_state <= EMIT_PAD;
            end else begin
              r_buf   <= '0;
              r_vld   <= 1'b0;
              r_rdy   <= 1'b1;
              r_last  <= 1'b0;
              r_state <= FILL;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

`ifdef KECCAK_PAD_ERR_EN
  logic r_err;
  assign w_bad = (in_bytes > BW'(NB)) || (in_last && in_bytes == '0 && r_cnt != '0);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_err <= 1'b0;
    else if (w_acc && w_bad) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign w_bad = 1'b0;
  assign err   = 1'b0;
`endif

  assign in_ready  = r_rdy;
  assign blk_valid = r_vld;
  assign blk_data  = r_buf;
  assign blk_last  = r_last;
endmodule
